// File: rtl/spi_regfile_bridge_if.sv
// Register-file bus between the SPI bridge (master) and the register file (slave).
// The bridge drives address, write data and the write strobe; the register file
// returns combinational read data for the current address.
interface spi_regfile_bridge_if #(
    parameter int aw = 7,
    parameter int dw = 8
);
    logic [aw-1:0] addr_o;
    logic [dw-1:0] data_o;
    logic          wren_o;
    logic [dw-1:0] data_i;

    modport master (
        output addr_o,
        output data_o,
        output wren_o,
        input  data_i
    );

    modport slave (
        input  addr_o,
        input  data_o,
        input  wren_o,
        output data_i
    );
endinterface

// File: rtl/spi_regfile_bridge.sv
// SPI slave (mode 0, MSB first) acting as the sole master of the register file.
// Frame: command byte (bit7 = R/nW, bits 6:0 = address) followed by dw data bits.
// Writes produce a one-clock wren_o pulse; reads serialise data_i onto MISO.
// Optional burst mode: define SPI_REGFILE_AUTOINC_EN to auto-increment the
// address after every data phase until cs_n is released.
module spi_regfile_bridge #(
    parameter int aw          = 7,
    parameter int dw          = 8,
    parameter int sync_stages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 spi_sck_i,
    input  logic                 spi_cs_n_i,
    input  logic                 spi_mosi_i,
    output logic                 spi_miso_o,
    output logic                 spi_miso_oe_o,
    spi_regfile_bridge_if.master rf
);

    // Synchroniser depth never drops below two flops.
    localparam int SS = (sync_stages < 2) ? 2 : sync_stages;
    // Counter wide enough for both the 8-bit command and the dw-bit data phase.
    localparam int CW = $clog2((dw > 8) ? dw : 8) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Synchroniser chains: index 0 is the first stage, SS-1 the last.
    logic [SS-1:0] sck_sync_q, sck_sync_d;
    logic [SS-1:0] cs_sync_q,  cs_sync_d;
    logic [SS-1:0] mosi_sync_q, mosi_sync_d;

    logic sck_rise, sck_fall, cs_fall, cs_n_s, mosi_s;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    cmd_sr_q, cmd_sr_d;
    logic [dw-1:0] rx_sr_q, rx_sr_d;
    logic [dw-1:0] tx_sr_q, tx_sr_d;
    logic          rnw_q, rnw_d;
    logic          prefetch_q, prefetch_d;
    logic          inc_pend_q, inc_pend_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [dw-1:0] data_q, data_d;
    logic          wren_q, wren_d;
    logic          miso_q, miso_d;

    // Shift each asynchronous SPI input into its synchroniser chain.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SS-2:0],  spi_sck_i};
        cs_sync_d   = {cs_sync_q[SS-2:0],   spi_cs_n_i};
        mosi_sync_d = {mosi_sync_q[SS-2:0], spi_mosi_i};
    end

    // Edge strobes from the last two stages; levels from the last stage.
    always_comb begin
        sck_rise = sck_sync_q[SS-2] & ~sck_sync_q[SS-1];
        sck_fall = ~sck_sync_q[SS-2] & sck_sync_q[SS-1];
        cs_fall  = ~cs_sync_q[SS-2] & cs_sync_q[SS-1];
        cs_n_s   = cs_sync_q[SS-1];
        mosi_s   = mosi_sync_q[SS-1];
    end

    // State register and datapath flops; cs_n chain resets to the idle (high) level
    // so that reset release is never mistaken for a chip-select falling edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rnw_q       <= 1'b0;
            prefetch_q  <= 1'b0;
            inc_pend_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rnw_q       <= rnw_d;
            prefetch_q  <= prefetch_d;
            inc_pend_q  <= inc_pend_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            miso_q      <= miso_d;
        end
    end

    // Frame FSM: next state, shift registers, register-file outputs and MISO.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        rnw_d      = rnw_q;
        prefetch_d = 1'b0;
        inc_pend_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        miso_d     = miso_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end

            CMD: begin
                miso_d = 1'b0;
                if (cs_n_s) begin
                    state_d = IDLE;
                end else if (sck_rise) begin
                    cmd_sr_d  = {cmd_sr_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(7)) begin
                        addr_d     = aw'(cmd_sr_d[6:0]);
                        rnw_d      = cmd_sr_d[7];
                        prefetch_d = cmd_sr_d[7];
                        bit_cnt_d  = '0;
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else begin
                    // Burst step: bump the address one clock after the write strobe,
                    // then prefetch read data at the new address on the clock after.
                    if (inc_pend_q) begin
                        addr_d     = addr_q + 1'b1;
                        prefetch_d = rnw_q;
                    end
                    if (prefetch_q) begin
                        tx_sr_d = rf.data_i;
                        miso_d  = rf.data_i[dw-1];
                    end else if (rnw_q && sck_fall && (bit_cnt_q != '0)) begin
                        // The MSB is already on MISO for the first data rise; only
                        // falls after a data rise advance the shifter.
                        tx_sr_d = {tx_sr_q[dw-2:0], 1'b0};
                        miso_d  = tx_sr_q[dw-2];
                    end
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (!rnw_q) begin
                            rx_sr_d = {rx_sr_q[dw-2:0], mosi_s};
                        end
                        if (bit_cnt_q == CW'(dw - 1)) begin
                            bit_cnt_d = '0;
                            if (!rnw_q) begin
                                data_d = rx_sr_d;
                                wren_d = 1'b1;
                            end
`ifdef SPI_REGFILE_AUTOINC_EN
                            inc_pend_d = 1'b1;
`else
                            state_d = DRAIN;
                            miso_d  = 1'b0;
`endif
                        end
                    end
                end
            end

            DRAIN: begin
                miso_d = 1'b0;
                if (cs_n_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Register-file and pad outputs.
    always_comb begin
        rf.addr_o     = addr_q;
        rf.data_o     = data_q;
        rf.wren_o     = wren_q;
        spi_miso_o    = miso_q;
        spi_miso_oe_o = ~cs_n_s & (state_q != IDLE);
    end

endmodule

// File: tb/tb_spi_regfile_bridge.sv
// Directed bench for spi_regfile_bridge: single writes/reads, abort, mid-frame
// reset, burst behaviour (both builds) and 100 random frames against a model.
module tb_spi_regfile_bridge;

`ifdef SPI_REGFILE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sck   = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso;
    logic oe;

    spi_regfile_bridge_if #(.aw(7), .dw(8)) rf_bus ();

    spi_regfile_bridge #(.aw(7), .dw(8), .sync_stages(2)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .spi_sck_i     (sck),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (oe),
        .rf            (rf_bus)
    );

    always #5 clk = ~clk;

    // Register-file model driven by the DUT; exp_mem is the bench's own expectation.
    logic [7:0] mem     [128];
    logic [7:0] exp_mem [128];

    assign rf_bus.data_i = mem[rf_bus.addr_o];

    always @(posedge clk) begin
        if (rf_bus.wren_o) mem[rf_bus.addr_o] <= rf_bus.data_o;
    end

    // One entry per clock that wren_o is high: {addr, data}.
    logic [14:0] wq [$];
    always @(negedge clk) begin
        if (rst_n && rf_bus.wren_o) wq.push_back({rf_bus.addr_o, rf_bus.data_o});
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drop cs_n and clock n bits of 'bits' MSB first; sck = clk/8. Leaves cs_n low.
    task automatic spi_bits(input logic [31:0] bits, input int n,
                            output logic [31:0] rx, output int oe_lo);
        cs_n  = 1'b0;
        rx    = '0;
        oe_lo = 0;
        clks(4);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            clks(4);
            sck = 1'b1;
            rx  = {rx[30:0], miso};
            if (!oe) oe_lo++;
            clks(4);
            sck = 1'b0;
        end
        clks(4);
    endtask

    task automatic cs_up(input int gap);
        cs_n = 1'b1;
        mosi = 1'b0;
        clks(gap);
    endtask

    logic [31:0] rx;
    int          oe_lo;
    logic [6:0]  ra;
    logic [7:0]  rd;
    logic        rnw;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'(i * 3 + 7);
            exp_mem[i] = 8'(i * 3 + 7);
        end
        mem[7'h45]     = 8'h3C;
        exp_mem[7'h45] = 8'h3C;

        // Reset state
        clks(3);
        check("rst_addr", 32'(rf_bus.addr_o), 32'h0);
        check("rst_data", 32'(rf_bus.data_o), 32'h0);
        check("rst_wren", 32'(rf_bus.wren_o), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_oe",   32'(oe),   32'h0);
        rst_n = 1'b1;
        clks(4);

        // Single write 0x05 <- 0xA5
        wq.delete();
        spi_bits({16'h0, 8'h05, 8'hA5}, 16, rx, oe_lo);
        cs_up(6);
        $display("txn write addr=05 data=a5 wren_count=%0d", wq.size());
        check("wr1_count", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) check("wr1_entry", 32'(wq[0]), 32'({7'h05, 8'hA5}));
        check("wr1_addr", 32'(rf_bus.addr_o), AUTOINC ? 32'h06 : 32'h05);
        check("wr1_data", 32'(rf_bus.data_o), 32'hA5);
        check("wr1_wren_idle", 32'(rf_bus.wren_o), 32'h0);
        exp_mem[7'h05] = 8'hA5;

        // Read 0x45 via cmd 0xC5 -> 0x3C on MISO
        wq.delete();
        check("rd1_oe_before", 32'(oe), 32'h0);
        spi_bits({16'h0, 8'hC5, 8'h00}, 16, rx, oe_lo);
        $display("txn read addr=45 miso=%02h", rx[7:0]);
        check("rd1_miso", 32'(rx[7:0]), 32'h3C);
        check("rd1_oe_during", 32'(oe_lo), 32'd0);
        cs_up(6);
        check("rd1_oe_after", 32'(oe), 32'h0);
        check("rd1_miso_after", 32'(miso), 32'h0);
        check("rd1_no_wren", 32'(wq.size()), 32'd0);

        // Write aborted after 12 bits
        wq.delete();
        spi_bits({20'h0, 8'h0A, 4'hF}, 12, rx, oe_lo);
        cs_up(6);
        $display("txn aborted write addr=0a wren_count=%0d", wq.size());
        check("abort_no_wren", 32'(wq.size()), 32'd0);
        check("abort_addr", 32'(rf_bus.addr_o), 32'h0A);
        check("abort_data_kept", 32'(rf_bus.data_o), 32'hA5);

        // Normal frame after abort
        wq.delete();
        spi_bits({16'h0, 8'h01, 8'h11}, 16, rx, oe_lo);
        cs_up(6);
        $display("txn write addr=01 data=11 wren_count=%0d", wq.size());
        check("post_abort_count", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) check("post_abort_entry", 32'(wq[0]), 32'({7'h01, 8'h11}));
        exp_mem[7'h01] = 8'h11;

        // Reset mid-DATA
        spi_bits({20'h0, 8'h03, 4'hF}, 12, rx, oe_lo);
        rst_n = 1'b0;
        #1;
        $display("txn reset mid-frame");
        check("mrst_addr", 32'(rf_bus.addr_o), 32'h0);
        check("mrst_data", 32'(rf_bus.data_o), 32'h0);
        check("mrst_wren", 32'(rf_bus.wren_o), 32'h0);
        check("mrst_miso", 32'(miso), 32'h0);
        check("mrst_oe",   32'(oe),   32'h0);
        cs_up(4);
        rst_n = 1'b1;
        clks(4);
        wq.delete();
        spi_bits({16'h0, 8'h02, 8'hFF}, 16, rx, oe_lo);
        cs_up(6);
        $display("txn write addr=02 data=ff wren_count=%0d", wq.size());
        check("post_rst_count", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) check("post_rst_entry", 32'(wq[0]), 32'({7'h02, 8'hFF}));
        exp_mem[7'h02] = 8'hFF;
        spi_bits({16'h0, 8'h82, 8'h00}, 16, rx, oe_lo);
        cs_up(6);
        $display("txn read addr=02 miso=%02h", rx[7:0]);
        check("post_rst_read", 32'(rx[7:0]), 32'hFF);

        // Burst at 0x7F: two data bytes
        wq.delete();
        spi_bits({8'h0, 8'h7F, 8'h10, 8'h20}, 24, rx, oe_lo);
        cs_up(6);
        $display("txn burst write addr=7f wren_count=%0d", wq.size());
        check("burst_count", 32'(wq.size()), AUTOINC ? 32'd2 : 32'd1);
        if (wq.size() >= 1) check("burst_entry0", 32'(wq[0]), 32'({7'h7F, 8'h10}));
        if (wq.size() >= 2) check("burst_entry1", 32'(wq[1]), 32'({7'h00, 8'h20}));
        check("burst_addr", 32'(rf_bus.addr_o), AUTOINC ? 32'h01 : 32'h7F);
        exp_mem[7'h7F] = 8'h10;
        if (AUTOINC) exp_mem[7'h00] = 8'h20;

        // Burst read at 0x7F: second byte is next address or idle-low MISO
        wq.delete();
        spi_bits({8'h0, 8'hFF, 16'h0}, 24, rx, oe_lo);
        cs_up(6);
        $display("txn burst read addr=7f miso=%04h", rx[15:0]);
        check("burst_rd_b0", 32'(rx[15:8]), 32'(exp_mem[7'h7F]));
        check("burst_rd_b1", 32'(rx[7:0]), AUTOINC ? 32'(exp_mem[7'h00]) : 32'h0);
        check("burst_rd_no_wren", 32'(wq.size()), 32'd0);

        // Random single frames against the expectation model
        for (int n = 0; n < 100; n++) begin
            rnw = 1'($urandom_range(0, 1));
            ra  = 7'($urandom_range(0, 127));
            rd  = 8'($urandom);
            wq.delete();
            spi_bits({16'h0, rnw, ra, rd}, 16, rx, oe_lo);
            cs_up(int'($urandom_range(3, 20)));
            if (rnw) begin
                $display("txn %0d read addr=%02h miso=%02h", n, ra, rx[7:0]);
                check("rand_rd", 32'(rx[7:0]), 32'(exp_mem[ra]));
                check("rand_rd_no_wren", 32'(wq.size()), 32'd0);
            end else begin
                $display("txn %0d write addr=%02h data=%02h wren_count=%0d", n, ra, rd, wq.size());
                check("rand_wr_count", 32'(wq.size()), 32'd1);
                if (wq.size() >= 1) check("rand_wr_entry", 32'(wq[0]), 32'({ra, rd}));
                exp_mem[ra] = rd;
            end
            check("rand_oe", 32'(oe_lo), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
